// File: rtl/perturb_cost_unit_if.sv
// Bundle of handshake, data and status signals for the perturbation cost unit.
interface perturb_cost_unit_if #(
    parameter int unsigned OUTPUT_SZ = 1,
    parameter int unsigned BITWIDTH  = 18
);
    logic                            dataReadyP;
    logic [OUTPUT_SZ*BITWIDTH-1:0]   networkOutput;
    logic [OUTPUT_SZ-1:0]            modelOutput;
    logic                            trainMode;
    logic                            trainingReady;
    logic [BITWIDTH-1:0]             costFunc;
    logic                            newCostFunc;
    logic                            busy;
    logic [31:0]                     errCount;
    logic [31:0]                     windowErr;
    logic                            windowDone;
    logic                            overrun;

    // Driver side (network / trainer).
    modport master (
        output dataReadyP, networkOutput, modelOutput, trainMode, trainingReady,
        input  costFunc, newCostFunc, busy, errCount, windowErr, windowDone, overrun
    );

    // Cost unit side.
    modport slave (
        input  dataReadyP, networkOutput, modelOutput, trainMode, trainingReady,
        output costFunc, newCostFunc, busy, errCount, windowErr, windowDone, overrun
    );
endinterface

// File: rtl/perturb_cost_unit.sv
// Perturbation-based cost unit: evaluates a nominal and a perturbed network pass through a
// shift-only sigmoid and squared-error loss, one channel per clock on a shared multiplier,
// and emits the saturated, scaled cost difference. Also tracks nominal mispredictions per window.
module perturb_cost_unit #(
    parameter int unsigned OUTPUT_SZ  = 1,
    parameter int unsigned QN         = 6,
    parameter int unsigned QM         = 11,
    parameter int unsigned DIFF_SHIFT = 5,
    parameter int unsigned ERR_WINDOW = 1000
) (
    input logic               clk_i,
    input logic               rst_i,
    perturb_cost_unit_if.slave bus
);
    localparam int unsigned BW  = QN + QM + 1;
    localparam int unsigned EW  = BW + 1;
    localparam int unsigned CW  = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
    // Each channel loss is at most 1.0, so the sum needs clog2(OUTPUT_SZ+1) extra bits.
    localparam int unsigned JW  = QM + 1 + $clog2(OUTPUT_SZ + 1);
    localparam int unsigned DW0 = JW + 1 + DIFF_SHIFT;
    localparam int unsigned DW  = (DW0 > BW + 1) ? DW0 : BW + 1;

    localparam logic [BW-1:0] One    = BW'(1) << QM;
    localparam logic [BW-1:0] Five   = BW'(5) << QM;
    localparam logic [BW-1:0] T2p375 = BW'(19) << (QM - 3);
    localparam logic [BW-1:0] C0p843 = BW'(27) << (QM - 5);
    localparam logic [BW-1:0] C0p625 = BW'(5) << (QM - 3);
    localparam logic [BW-1:0] Half   = BW'(1) << (QM - 1);

    localparam logic signed [DW-1:0] SatMax = {{(DW - BW + 1){1'b0}}, {(BW - 1){1'b1}}};
    localparam logic signed [DW-1:0] SatMin = {{(DW - BW + 1){1'b1}}, {(BW - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StCalcNom, StWaitPert, StCalcPert, StEmit, StWaitTrain
    } state_e;

    state_e                      state_q, state_d;
    logic                        prev_q, prev_d;
    logic [OUTPUT_SZ*BW-1:0]     x_q, x_d;
    logic [OUTPUT_SZ-1:0]        t_q, t_d;
    logic                        train_q, train_d;
    logic [CW-1:0]               ch_q, ch_d;
    logic [JW-1:0]               acc_q, acc_d;
    logic [JW-1:0]               jnom_q, jnom_d;
    logic [BW-1:0]               cost_q, cost_d;
    logic                        newcost_q, newcost_d;
    logic [31:0]                 err_q, err_d;
    logic [31:0]                 win_err_q, win_err_d;
    logic                        win_done_q, win_done_d;
    logic                        overrun_q, overrun_d;
    logic [31:0]                 eval_q, eval_d;

    logic                        rise;
    logic [BW-1:0]               x_sel;
    logic                        t_sel;
    logic [BW-1:0]               a_abs, y_pos, s_val, t_val;
    logic signed [EW-1:0]        e_val;
    logic signed [2*EW-1:0]      prod, loss_w;
    logic [JW-1:0]               acc_sum;
    logic                        mismatch, last_ch;
    logic [31:0]                 err_inc;
    logic signed [DW-1:0]        diff;

    // Datapath for the current channel: sigmoid, error, single squaring multiplier.
    always_comb begin
        x_sel = '0;
        t_sel = 1'b0;
        for (int unsigned c = 0; c < OUTPUT_SZ; c++) begin
            if (ch_q == CW'(c)) begin
                x_sel = x_q[c*BW +: BW];
                t_sel = t_q[c];
            end
        end
        a_abs = x_sel[BW-1] ? (~x_sel) + BW'(1) : x_sel;
        if (a_abs >= Five) begin
            y_pos = One;
        end else if (a_abs >= T2p375) begin
            y_pos = (a_abs >> 5) + C0p843;
        end else if (a_abs >= One) begin
            y_pos = (a_abs >> 3) + C0p625;
        end else begin
            y_pos = (a_abs >> 2) + Half;
        end
        s_val    = x_sel[BW-1] ? One - y_pos : y_pos;
        t_val    = t_sel ? One : '0;
        e_val    = $signed({1'b0, t_val}) - $signed({1'b0, s_val});
        prod     = e_val * e_val;
        loss_w   = prod >>> QM;
        acc_sum  = acc_q + JW'(loss_w);
        mismatch = (~x_sel[BW-1]) != t_sel;
        last_ch  = (ch_q == CW'(OUTPUT_SZ - 1));
        err_inc  = err_q + 32'(mismatch);
        diff     = ($signed({{(DW - JW){1'b0}}, acc_q}) -
                    $signed({{(DW - JW){1'b0}}, jnom_q})) <<< DIFF_SHIFT;
    end

    // Next-state and register updates for the evaluation FSM.
    always_comb begin
        state_d    = state_q;
        prev_d     = bus.dataReadyP;
        x_d        = x_q;
        t_d        = t_q;
        train_d    = train_q;
        ch_d       = ch_q;
        acc_d      = acc_q;
        jnom_d     = jnom_q;
        cost_d     = cost_q;
        newcost_d  = 1'b0;
        err_d      = err_q;
        win_err_d  = win_err_q;
        win_done_d = 1'b0;
        overrun_d  = overrun_q;
        eval_d     = eval_q;
        rise       = bus.dataReadyP & ~prev_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    x_d     = bus.networkOutput;
                    t_d     = bus.modelOutput;
                    train_d = bus.trainMode;
                    ch_d    = '0;
                    acc_d   = '0;
                    state_d = StCalcNom;
                end
            end
            StCalcNom: begin
                acc_d = acc_sum;
                ch_d  = ch_q + CW'(1);
                err_d = err_inc;
                if (last_ch) begin
                    ch_d = '0;
                    if (eval_q == 32'(ERR_WINDOW - 1)) begin
                        win_err_d  = err_inc;
                        win_done_d = 1'b1;
                        err_d      = '0;
                        eval_d     = '0;
                    end else begin
                        eval_d = eval_q + 32'd1;
                    end
                    if (train_q) begin
                        jnom_d  = acc_sum;
                        state_d = StWaitPert;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitPert: begin
                // modelOutput from the nominal capture is kept for the perturbed pass.
                if (rise) begin
                    x_d     = bus.networkOutput;
                    ch_d    = '0;
                    acc_d   = '0;
                    state_d = StCalcPert;
                end
            end
            StCalcPert: begin
                acc_d = acc_sum;
                ch_d  = ch_q + CW'(1);
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (diff > SatMax) begin
                    cost_d = BW'(SatMax);
                end else if (diff < SatMin) begin
                    cost_d = BW'(SatMin);
                end else begin
                    cost_d = BW'(diff);
                end
                newcost_d = 1'b1;
                state_d   = StWaitTrain;
            end
            StWaitTrain: begin
                if (bus.trainingReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rise && (state_q == StCalcNom || state_q == StCalcPert ||
                     state_q == StEmit || state_q == StWaitTrain)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with synchronous reset; edge detector held low during reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            prev_q     <= 1'b0;
            x_q        <= '0;
            t_q        <= '0;
            train_q    <= 1'b0;
            ch_q       <= '0;
            acc_q      <= '0;
            jnom_q     <= '0;
            cost_q     <= '0;
            newcost_q  <= 1'b0;
            err_q      <= '0;
            win_err_q  <= '0;
            win_done_q <= 1'b0;
            overrun_q  <= 1'b0;
            eval_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            x_q        <= x_d;
            t_q        <= t_d;
            train_q    <= train_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            jnom_q     <= jnom_d;
            cost_q     <= cost_d;
            newcost_q  <= newcost_d;
            err_q      <= err_d;
            win_err_q  <= win_err_d;
            win_done_q <= win_done_d;
            overrun_q  <= overrun_d;
            eval_q     <= eval_d;
        end
    end

    assign bus.costFunc    = cost_q;
    assign bus.newCostFunc = newcost_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.errCount    = err_q;
    assign bus.windowErr   = win_err_q;
    assign bus.windowDone  = win_done_q;
    assign bus.overrun     = overrun_q;
endmodule
